// File: rtl/dmem_bus.sv
// Data memory for the MEM stage: request/response handshake, WAIT wait states, byte-lane stores,
// sign/zero-extended loads. Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
module dmem_bus #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAITS, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   mem [DEPTH];

  logic          hs;
  logic [AW-1:0] idx;
  logic          legal;
  logic          misalign;
  logic          access_err;
  logic          mem_we;
  logic [3:0]    wmask;
  logic [31:0]   wword;
  logic          unused_addr_hi;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {lo, 3'b000};
    b  = sh[7:0];
    h  = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  assign hs             = req_valid && (state_q == IDLE);
  assign idx            = addr_q[AW+1:2];
  assign unused_addr_hi = ^addr[31:AW+2];

  assign legal = we_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                      : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign access_err = !legal || misalign;
  assign mem_we     = (state_q == ACCESS) && we_q && !access_err;

  // Store data is replicated across lanes; the mask picks which lanes land.
  always_comb begin
    wmask = 4'b1111;
    wword = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        wmask = 4'b0001 << addr_q[1:0];
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (hs) begin
      we_d     = we;
      funct3_d = funct3;
      addr_d   = addr[AW+1:0];
      wdata_d  = wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (WAIT > 0) begin
            state_d = WAITS;
            cnt_d   = 4'(WAIT - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAITS: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = access_err;
        rdata_d = (we_q || access_err) ? 32'h0 : load_extend(mem[idx], funct3_q, addr_q[1:0]);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields and memory are datapath only; reset leaves them alone.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    funct3_q <= funct3_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign rdata      = rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_bus.sv
// Scoreboard bench for dmem_bus: three instances (WAIT=1, WAIT=0, WAIT=4) sharing the request fields.
module tb_dmem_bus;

  logic        clk = 1'b0;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] rdata      [3];
  logic        err        [3];
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } op_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_bus #(.DEPTH(1024), .WAIT(1)) u_w1 (
    .clk(clk), .rst(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid[0]), .rdata(rdata[0]), .err(err[0]));

  dmem_bus #(.DEPTH(1024), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid[1]), .rdata(rdata[1]), .err(err[1]));

  dmem_bus #(.DEPTH(1024), .WAIT(4)) u_w4 (
    .clk(clk), .rst(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid[2]), .rdata(rdata[2]), .err(err[2]));

  // Drives one request, scrambles the inputs after handshake, and waits (bounded) for the response.
  task automatic send(input int s, input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat, output logic hold_ok);
    int n;
    n = 0;
    rd = 32'h0;
    e = 1'b0;
    lat = -1;
    hold_ok = 1'b0;
    @(negedge clk);
    while (req_ready[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid[s] = 1'b1;
    we = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid[s] === 1'b1) begin
        lat = k;
        rd = rdata[s];
        e = err[s];
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      hold_ok = (resp_valid[s] === 1'b0) && (req_ready[s] === 1'b1) &&
                (rdata[s] === rd) && (err[s] === e);
    end
  endtask

  function automatic op_t mk(input logic w, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    op_t o;
    o.w = w; o.f3 = f3; o.a = a; o.wd = wd; o.erd = erd; o.eerr = eerr;
    return o;
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1 || resp_valid[s] !== 1'b0 || rdata[s] !== 32'h0 || err[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got ready=%b resp=%b rdata=%h err=%b, want 1 0 00000000 0",
                 s, req_ready[s], resp_valid[s], rdata[s], err[s]);
      end
    end
  endtask

  task automatic test_ops(input int s, input int wait_n, input string name, input op_t ops[$]);
    logic [31:0] rd;
    logic        e, hold;
    int          lat;
    exp_t        ex;
    foreach (ops[i]) begin
      ex.rdata = ops[i].erd;
      ex.err   = ops[i].eerr;
      ex.lat   = 2 + wait_n;
      sb_q.push_back(ex);
      send(s, ops[i].w, ops[i].f3, ops[i].a, ops[i].wd, rd, e, lat, hold);
      ex = sb_q.pop_front();
      checks++;
      if (rd !== ex.rdata || e !== ex.err) begin
        errors++;
        $display("FAIL %s[%0d]: got rdata=%h err=%b, want rdata=%h err=%b", name, i, rd, e, ex.rdata, ex.err);
      end
      checks++;
      if (lat !== ex.lat || hold !== 1'b1) begin
        errors++;
        $display("FAIL %s_timing[%0d]: got latency=%0d single_pulse_hold=%b, want latency=%0d hold=1",
                 name, i, lat, hold, ex.lat);
      end
    end
  endtask

  task automatic test_word();
    op_t ops[$];
    ops.push_back(mk(1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 0));
    ops.push_back(mk(0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 0));
    test_ops(0, 1, "word", ops);
  endtask

  task automatic test_lanes();
    op_t ops[$];
    ops.push_back(mk(1, 3'b010, 32'h40, 32'h0, 32'h0, 0));
    ops.push_back(mk(1, 3'b000, 32'h41, 32'hAAAAAA7F, 32'h0, 0));
    ops.push_back(mk(1, 3'b001, 32'h42, 32'h55558001, 32'h0, 0));
    ops.push_back(mk(0, 3'b010, 32'h40, 32'h0, 32'h80017F00, 0));
    ops.push_back(mk(0, 3'b000, 32'h43, 32'h0, 32'hFFFFFF80, 0));
    ops.push_back(mk(0, 3'b100, 32'h43, 32'h0, 32'h00000080, 0));
    ops.push_back(mk(0, 3'b101, 32'h42, 32'h0, 32'h00008001, 0));
    ops.push_back(mk(0, 3'b001, 32'h42, 32'h0, 32'hFFFF8001, 0));
    ops.push_back(mk(0, 3'b000, 32'h41, 32'h0, 32'h0000007F, 0));
    test_ops(0, 1, "lanes", ops);
  endtask

  task automatic test_misalign();
    op_t ops[$];
`ifdef DMEM_MISALIGN_CHECK_EN
    ops.push_back(mk(0, 3'b010, 32'h42, 32'h0, 32'h0, 1));
    ops.push_back(mk(0, 3'b001, 32'h43, 32'h0, 32'h0, 1));
    ops.push_back(mk(1, 3'b001, 32'h41, 32'h1234, 32'h0, 1));
    ops.push_back(mk(0, 3'b010, 32'h40, 32'h0, 32'h80017F00, 0));
`else
    ops.push_back(mk(0, 3'b010, 32'h42, 32'h0, 32'h80017F00, 0));
    ops.push_back(mk(0, 3'b001, 32'h43, 32'h0, 32'hFFFF8001, 0));
    ops.push_back(mk(1, 3'b001, 32'h41, 32'h1234, 32'h0, 0));
    ops.push_back(mk(0, 3'b010, 32'h40, 32'h0, 32'h80011234, 0));
`endif
    test_ops(0, 1, "misalign", ops);
  endtask

  task automatic test_illegal();
    op_t ops[$];
    ops.push_back(mk(1, 3'b010, 32'h40, 32'h0BADF00D, 32'h0, 0));
    ops.push_back(mk(1, 3'b011, 32'h40, 32'hFFFFFFFF, 32'h0, 1));
    ops.push_back(mk(1, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h0, 1));
    ops.push_back(mk(1, 3'b110, 32'h40, 32'hFFFFFFFF, 32'h0, 1));
    ops.push_back(mk(0, 3'b110, 32'h40, 32'h0, 32'h0, 1));
    ops.push_back(mk(0, 3'b111, 32'h40, 32'h0, 32'h0, 1));
    ops.push_back(mk(0, 3'b011, 32'h40, 32'h0, 32'h0, 1));
    ops.push_back(mk(0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 0));
    test_ops(0, 1, "illegal", ops);
  endtask

  task automatic test_wrap();
    op_t ops[$];
    ops.push_back(mk(1, 3'b010, 32'h1000, 32'h12345678, 32'h0, 0));
    ops.push_back(mk(0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0));
    ops.push_back(mk(1, 3'b010, 32'h0FFC, 32'hA5A5A5A5, 32'h0, 0));
    ops.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'hA5A5A5A5, 0));
    test_ops(0, 1, "wrap", ops);
  endtask

  // Back-to-back traffic on the zero-wait instance against a bench-side memory model.
  task automatic test_back_to_back();
    op_t         ops[$];
    logic [31:0] m [8];
    logic [31:0] w, a, wd, ev, sh;
    logic        st, uns;
    int          size, wi;
    logic [1:0]  lo;
    for (int i = 0; i < 8; i++) begin
      m[i] = $urandom;
      ops.push_back(mk(1, 3'b010, 32'h100 + 32'(4 * i), m[i], 32'h0, 0));
    end
    for (int i = 0; i < 24; i++) begin
      st   = 1'($urandom);
      size = $urandom_range(0, 2);
      uns  = (size < 2) ? 1'($urandom) : 1'b0;
      wi   = $urandom_range(0, 7);
      lo   = (size == 0) ? 2'($urandom) : (size == 1) ? {1'($urandom), 1'b0} : 2'b00;
      a    = 32'h100 + 32'(4 * wi) + 32'(lo);
      wd   = $urandom;
      ev   = 32'h0;
      if (st) begin
        uns = 1'b0;
        if (size == 0)      m[wi][8*lo +: 8] = wd[7:0];
        else if (size == 1) m[wi][8*lo +: 16] = wd[15:0];
        else                m[wi] = wd;
      end else begin
        w  = m[wi];
        sh = w >> (8 * lo);
        if (size == 0)      ev = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        else if (size == 1) ev = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else                ev = w;
      end
      ops.push_back(mk(st, {uns, 2'(size)}, a, wd, ev, 0));
    end
    test_ops(1, 0, "b2b", ops);
  endtask

  task automatic test_reset_mid();
    op_t ops[$];
    int  seen;
    ops.push_back(mk(1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0));
    test_ops(2, 4, "pre_reset", ops);
    @(negedge clk);
    req_valid[2] = 1'b1;
    we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h22222222;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    #1;
    checks++;
    if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ready=%b resp=%b, want ready=1 resp=0", req_ready[2], resp_valid[2]);
    end
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL dropped_req: got resp_pulses=%0d ready=%b, want 0 and 1", seen, req_ready[2]);
    end
    ops.delete();
    ops.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0));
    test_ops(2, 4, "post_reset", ops);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0;
      req_valid[s] = 1'b0;
    end
    we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;
    @(negedge clk);
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Parametrised data memory for the pipelined RISC-V core's MEM stage, with a request/response handshake and a configurable wait-state counter. It supports RV32I byte, halfword and word stores with byte-lane masking. Loads are sign- or zero-extended per funct3. Illegal encodings are flagged on the response, and misaligned accesses are optionally flagged as well. Backpressure via `req_ready` lets the hazard unit stall the pipeline while an access is in flight.

## Interface
- `DEPTH`, 1024: memory depth in 32-bit words; power of two, 16..65536.
- `WAIT`, 1: wait states per access, 0..15.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; equals (state == IDLE).
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I load/store size/sign code.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `resp_valid` out 1: one-cycle pulse, request completed.
- `rdata` out 32: load result, extended; 0 for stores and errored requests; held until next response.
- `err` out 1: qualifies `resp_valid`; illegal funct3 or (with macro) misaligned access.

## Operation
- Request fields are captured into internal registers on handshake (`req_valid && req_ready`). After capture, inputs may change freely.
- Word index is `addr[$clog2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Legal loads:
  - 000 LB and 100 LBU select the byte at `addr[1:0]`.
  - 001 LH and 101 LHU select the halfword at `addr[1]`.
  - 010 LW selects the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Legal stores:
  - 000 SB writes byte lane `addr[1:0]` with `wdata[7:0]`.
  - 001 SH writes half lane `addr[1]` with `wdata[15:0]`.
  - 010 SW writes all four lanes.
  - Unselected lanes are unchanged.
- Illegal funct3 (loads 011/110/111; stores 011 and 1xx): no write, `rdata` = 0, `err` = 1.
- FSM states and transitions:
  - IDLE → WAITS on handshake if WAIT>0; IDLE → ACCESS if WAIT==0.
  - WAITS: a counter loads WAIT-1 and decrements each cycle; WAITS → ACCESS when it reaches 0.
  - ACCESS: the memory write is committed or the read is sampled at the end of this cycle; ACCESS → RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle; RESP → IDLE.
- There is exactly one outstanding request; `req_valid` is ignored outside IDLE.
- Memory contents are not cleared by reset. Simulation initialises all words to 0.

## Timing
- Handshake in cycle N gives `resp_valid` in cycle N+2+WAIT. The store commits at the rising edge that begins cycle N+2+WAIT.
- Throughput is one request per WAIT+3 cycles; `req_ready` is next high in cycle N+3+WAIT.
- `rdata` and `err` are registered and become valid together with `resp_valid`.
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `rdata` = 0, `err` = 0, counter 0.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately (asynchronously) and the request is dropped.
  - The store is lost unless its commit edge already occurred.
  - No `resp_valid` is issued for the dropped request.
- Load from a location written by the previous request returns the new data (the commit precedes the next request's access).

## Configuration
- `DMEM_MISALIGN_CHECK_EN`:
  - Defined: a halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, completes with `err` = 1. It performs no write and returns `rdata` = 0, with the same latency as a normal access.
  - Undefined: misalignment is not flagged. Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`. Data is force-aligned and `err` reflects illegal funct3 only.

## Test plan
- WAIT=1: SW 0xDEADBEEF to 0x40, then LW 0x40 → `resp_valid` 3 cycles after each handshake; rdata=0xDEADBEEF, err=0.
- SB 0x7F to 0x41, SH 0x8001 to 0x42 over word 0x40=0 → LW 0x40 = 0x80017F00; LB 0x43 = 0xFFFFFF80; LBU 0x43 = 0x00000080; LHU 0x42 = 0x00008001.
- Misaligned LW 0x42 with macro defined → err=1, rdata=0. Same access without the macro → err=0, returns word 0x40.
- funct3=011 store to 0x40 → err=1, memory unchanged; funct3=110 load → err=1, rdata=0.
- DEPTH=1024: SW 0x12345678 to 0x1000 → LW 0x0 = 0x12345678 (wrap). WAIT=0 → response 2 cycles after handshake.
- WAIT=4: assert rst low 2 cycles after an SW handshake → resp_valid never pulses, target word unchanged, req_ready=1 after reset release.
